// File: rtl/clk_rst_seq_if.sv
// Sequencer-side bundle: DCM supervision, per-domain resets and status.
interface clk_rst_seq_if #(
  parameter int N_CH = 4
);
  logic            DCM_LOCKED;
  logic            DCM_RST;
  logic [N_CH-1:0] CH_RST;
  logic            READY;
  logic [7:0]      RETRY_CNT;
  logic [7:0]      LOSS_CNT;
  logic [2:0]      STATE;

  // Sequencer side: watches the lock, drives every reset and status output.
  modport master (
    input  DCM_LOCKED,
    output DCM_RST,
    output CH_RST,
    output READY,
    output RETRY_CNT,
    output LOSS_CNT,
    output STATE
  );

  // Consumer side: the clocking wrapper and the downstream domains.
  modport slave (
    output DCM_LOCKED,
    input  DCM_RST,
    input  CH_RST,
    input  READY,
    input  RETRY_CNT,
    input  LOSS_CNT,
    input  STATE
  );
endinterface

// File: rtl/clk_rst_seq.sv
// Reset sequencer for one MMCM/DCM: pulses the DCM reset, supervises lock
// with timeout/retry and a stability window, then releases N_CH downstream
// reset domains in staggered order. Lock loss after release re-arms it all.
module clk_rst_seq #(
  parameter int RST_CYCLES   = 255,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 1023,
  parameter int N_CH         = 4,
  parameter int STAGGER      = 16,
  parameter int CNT_W        = 24
) (
  input  logic              CLK,
  input  logic              RST,
  clk_rst_seq_if.master     bus
);

  typedef enum logic [2:0] {
    S_RST     = 3'd0,
    S_WAIT    = 3'd1,
    S_STABLE  = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  // Only meaningful for N_CH > 1; with a single channel S_RELEASE is skipped.
  localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'((N_CH - 1) * STAGGER - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             lock_s;
  logic             dcm_rst;
  logic [N_CH-1:0]  ch_rst;
  logic             ready;
  logic [7:0]       retry_cnt;
  logic [7:0]       loss_cnt;

  // Two-flop synchroniser bringing the asynchronous DCM lock into CLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= bus.DCM_LOCKED;
      lock_s <= sync1;
    end
  end

  // Sequencer FSM with the shared counter and all registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_RST;
      cnt       <= '0;
      dcm_rst   <= 1'b1;
      ch_rst    <= '1;
      ready     <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else if ((state == S_RELEASE || state == S_RUN) && !lock_s) begin
      // Lock loss after release outranks any release step or S_RUN entry.
      state    <= S_RST;
      cnt      <= '0;
      dcm_rst  <= 1'b1;
      ch_rst   <= '1;
      ready    <= 1'b0;
      if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
    end else begin
      case (state)
        S_RST: begin
          dcm_rst <= 1'b1;
          if (cnt == RST_LAST) begin
            state   <= S_WAIT;
            cnt     <= '0;
            dcm_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT: begin
          if (lock_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state   <= S_RST;
            cnt     <= '0;
            dcm_rst <= 1'b1;
            if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STABLE: begin
          if (!lock_s) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            cnt       <= '0;
            ch_rst[0] <= 1'b0;
            if (N_CH == 1) begin
              state <= S_RUN;
              ready <= 1'b1;
            end else begin
              state <= S_RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RELEASE: begin
          // Channel i drops when cnt reaches i*STAGGER-1 (i*STAGGER after ch 0).
          for (int unsigned i = 1; i < N_CH; i++) begin
            if (cnt == CNT_W'(i * STAGGER - 1)) ch_rst[i] <= 1'b0;
          end
          if (cnt == REL_LAST) begin
            state <= S_RUN;
            cnt   <= '0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          cnt <= cnt + 1'b1;
        end

        default: begin
          state   <= S_RST;
          cnt     <= '0;
          dcm_rst <= 1'b1;
          ch_rst  <= '1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DCM_RST   = dcm_rst;
  assign bus.CH_RST    = ch_rst;
  assign bus.READY     = ready;
  assign bus.RETRY_CNT = retry_cnt;
  assign bus.LOSS_CNT  = loss_cnt;
  assign bus.STATE     = state;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with small timing parameters.
`timescale 1ns/1ps
module tb_clk_rst_seq;

  localparam int N_CH = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  clk_rst_seq_if #(.N_CH(N_CH)) bus ();

  clk_rst_seq #(
    .RST_CYCLES  (8),
    .LOCK_TIMEOUT(32),
    .LOCK_STABLE (4),
    .N_CH        (N_CH),
    .STAGGER     (2),
    .CNT_W       (24)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         n;
    logic       lock;
    logic [2:0] st;
    logic       dcm;
    logic [2:0] ch;
    logic       rdy;
    logic [7:0] retry;
    logic [7:0] loss;
  } vec_t;

  vec_t rows[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(int n, logic lock, logic [2:0] st, logic dcm,
                              logic [2:0] ch, logic rdy, logic [7:0] retry,
                              logic [7:0] loss);
    vec_t v;
    v.n = n; v.lock = lock; v.st = st; v.dcm = dcm; v.ch = ch;
    v.rdy = rdy; v.retry = retry; v.loss = loss;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [2:0] st, logic dcm, logic [2:0] ch,
                         logic rdy, logic [7:0] retry, logic [7:0] loss);
    chk({tag, ".state"}, 32'(bus.STATE),     32'(st));
    chk({tag, ".dcm"},   32'(bus.DCM_RST),   32'(dcm));
    chk({tag, ".ch"},    32'(bus.CH_RST),    32'(ch));
    chk({tag, ".ready"}, 32'(bus.READY),     32'(rdy));
    chk({tag, ".retry"}, 32'(bus.RETRY_CNT), 32'(retry));
    chk({tag, ".loss"},  32'(bus.LOSS_CNT),  32'(loss));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Each row sets DCM_LOCKED, then runs n edges checking outputs after each.
  task automatic apply_rows(int lo, int hi);
    for (int r = lo; r <= hi; r++) begin
      bus.DCM_LOCKED = rows[r].lock;
      for (int k = 0; k < rows[r].n; k++) begin
        step();
        chk_all($sformatf("row%0d.%0d", r, k), rows[r].st, rows[r].dcm,
                rows[r].ch, rows[r].rdy, rows[r].retry, rows[r].loss);
      end
    end
  endtask

  initial begin
    // 0..5: nominal bring-up with lock held high
    rows.push_back(mk(7, 1'b1, 3'd0, 1'b1, 3'b111, 1'b0, 8'd0, 8'd0));
    rows.push_back(mk(1, 1'b1, 3'd1, 1'b0, 3'b111, 1'b0, 8'd0, 8'd0));
    rows.push_back(mk(4, 1'b1, 3'd2, 1'b0, 3'b111, 1'b0, 8'd0, 8'd0));
    rows.push_back(mk(2, 1'b1, 3'd3, 1'b0, 3'b110, 1'b0, 8'd0, 8'd0));
    rows.push_back(mk(2, 1'b1, 3'd3, 1'b0, 3'b100, 1'b0, 8'd0, 8'd0));
    rows.push_back(mk(3, 1'b1, 3'd4, 1'b0, 3'b000, 1'b1, 8'd0, 8'd0));
    // 6..7: lock loss in S_RUN (seen 3 edges later through the synchroniser)
    rows.push_back(mk(2, 1'b0, 3'd4, 1'b0, 3'b000, 1'b1, 8'd0, 8'd0));
    rows.push_back(mk(1, 1'b0, 3'd0, 1'b1, 3'b111, 1'b0, 8'd0, 8'd1));
    // 8..13: re-sequence, lock lost while CH_RST=110
    rows.push_back(mk(7, 1'b1, 3'd0, 1'b1, 3'b111, 1'b0, 8'd0, 8'd1));
    rows.push_back(mk(1, 1'b1, 3'd1, 1'b0, 3'b111, 1'b0, 8'd0, 8'd1));
    rows.push_back(mk(3, 1'b1, 3'd2, 1'b0, 3'b111, 1'b0, 8'd0, 8'd1));
    rows.push_back(mk(1, 1'b0, 3'd2, 1'b0, 3'b111, 1'b0, 8'd0, 8'd1));
    rows.push_back(mk(1, 1'b0, 3'd3, 1'b0, 3'b110, 1'b0, 8'd0, 8'd1));
    rows.push_back(mk(1, 1'b0, 3'd0, 1'b1, 3'b111, 1'b0, 8'd0, 8'd2));
    // 14..20: no lock, two timeouts at 40-cycle spacing
    rows.push_back(mk(7, 1'b0, 3'd0, 1'b1, 3'b111, 1'b0, 8'd0, 8'd2));
    rows.push_back(mk(32, 1'b0, 3'd1, 1'b0, 3'b111, 1'b0, 8'd0, 8'd2));
    rows.push_back(mk(1, 1'b0, 3'd0, 1'b1, 3'b111, 1'b0, 8'd1, 8'd2));
    rows.push_back(mk(7, 1'b0, 3'd0, 1'b1, 3'b111, 1'b0, 8'd1, 8'd2));
    rows.push_back(mk(32, 1'b0, 3'd1, 1'b0, 3'b111, 1'b0, 8'd1, 8'd2));
    rows.push_back(mk(1, 1'b0, 3'd0, 1'b1, 3'b111, 1'b0, 8'd2, 8'd2));
    rows.push_back(mk(7, 1'b0, 3'd0, 1'b1, 3'b111, 1'b0, 8'd2, 8'd2));
    // 21..30: partial period then relock with a one-cycle glitch in S_STABLE
    rows.push_back(mk(1, 1'b1, 3'd1, 1'b0, 3'b111, 1'b0, 8'd2, 8'd2));
    rows.push_back(mk(2, 1'b1, 3'd2, 1'b0, 3'b111, 1'b0, 8'd2, 8'd2));
    rows.push_back(mk(1, 1'b0, 3'd2, 1'b0, 3'b111, 1'b0, 8'd2, 8'd2));
    rows.push_back(mk(1, 1'b1, 3'd2, 1'b0, 3'b111, 1'b0, 8'd2, 8'd2));
    rows.push_back(mk(1, 1'b1, 3'd1, 1'b0, 3'b111, 1'b0, 8'd2, 8'd2));
    rows.push_back(mk(4, 1'b1, 3'd2, 1'b0, 3'b111, 1'b0, 8'd2, 8'd2));
    rows.push_back(mk(2, 1'b1, 3'd3, 1'b0, 3'b110, 1'b0, 8'd2, 8'd2));
    rows.push_back(mk(2, 1'b1, 3'd3, 1'b0, 3'b100, 1'b0, 8'd2, 8'd2));
    rows.push_back(mk(3, 1'b1, 3'd4, 1'b0, 3'b000, 1'b1, 8'd2, 8'd2));

    bus.DCM_LOCKED = 1'b1;
    RST = 1'b1;
    #22;
    chk_all("reset", 3'd0, 1'b1, 3'b111, 1'b0, 8'd0, 8'd0);
    // Release RST between edges
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;

    // Rows 14..20 start at the loss edge of row 13; the lock was set low
    // before row 20's first step, so the sync pipe stays low into row 21.
    // Row 20 is the RST phase after timeout 2; row 21 starts at its edge 8
    // with lock already high for 7 edges (set at row 21 start is too late),
    // so raise the lock before row 20 instead.
    apply_rows(0, 19);
    bus.DCM_LOCKED = 1'b1;
    for (int k = 0; k < rows[20].n; k++) begin
      step();
      chk_all($sformatf("row20.%0d", k), rows[20].st, rows[20].dcm,
              rows[20].ch, rows[20].rdy, rows[20].retry, rows[20].loss);
    end
    apply_rows(21, 30);

    // Saturation: lose lock in S_RUN, then force 300 timeouts.
    bus.DCM_LOCKED = 1'b0;
    repeat (3) step();
    chk_all("loss3", 3'd0, 1'b1, 3'b111, 1'b0, 8'd2, 8'd3);
    repeat (40 * 252) step();
    chk_all("retry254", 3'd0, 1'b1, 3'b111, 1'b0, 8'd254, 8'd3);
    repeat (40) step();
    chk("retry255", 32'(bus.RETRY_CNT), 32'd255);
    repeat (40 * 47) step();
    chk_all("retry_sat", 3'd0, 1'b1, 3'b111, 1'b0, 8'd255, 8'd3);

    // Relock, reach S_RELEASE with CH_RST=110, then async reset between edges.
    bus.DCM_LOCKED = 1'b1;
    repeat (14) step();
    chk_all("pre_async", 3'd3, 1'b0, 3'b110, 1'b0, 8'd255, 8'd3);
    #2;
    RST = 1'b1;
    #1;
    chk_all("async_rst", 3'd0, 1'b1, 3'b111, 1'b0, 8'd0, 8'd0);
    repeat (3) step();
    chk_all("rst_hold", 3'd0, 1'b1, 3'b111, 1'b0, 8'd0, 8'd0);
    #3;
    RST = 1'b0;
    #1;
    apply_rows(0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_rst_seq.md
Name: clk_rst_seq

Overview:
- Parametrised reset sequencer for a board clocking wrapper. It runs on the free-running buffered board clock and drives the reset of one MMCM/DCM.
- It watches the DCM lock, with timeout and retry, requires the lock to be stable, then releases N_CH downstream reset domains in staggered order.
- Lock loss re-arms the whole sequence.
- It succeeds the fixed 255-cycle power-on DCM reset counter with configurable timing, lock supervision and multi-domain reset release.

Parameters:
- RST_CYCLES, 255: cycles DCM_RST is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 65535: cycles to wait for lock before re-pulsing DCM_RST (>=1).
- LOCK_STABLE, 1023: cycles the synchronised lock must stay high before any release (>=1).
- N_CH, 4: number of downstream reset outputs (1..16).
- STAGGER, 16: cycles between successive channel releases (>=1).
- CNT_W, 24: internal counter width; every cycle parameter and (N_CH-1)*STAGGER must be < 2^CNT_W.

Ports:
- CLK  in  1  free-running reference clock (buffered board clock, not the DCM output).
- RST  in  1  asynchronous, active-high reset.
- DCM_LOCKED  in  1  DCM lock, asynchronous to CLK.
- DCM_RST  out  1  reset to the DCM, registered.
- CH_RST  out  N_CH  per-domain resets, active high, registered.
- READY  out  1  high when all channels are released.
- RETRY_CNT  out  8  lock-timeout count, saturating at 255.
- LOSS_CNT  out  8  lock-loss-after-release count, saturating at 255.
- STATE  out  3  current state: 0=S_RST, 1=S_WAIT, 2=S_STABLE, 3=S_RELEASE, 4=S_RUN.

Behaviour:
- Reset (RST=1, async):
  - State S_RST, counter 0.
  - DCM_RST=1, CH_RST all ones, READY=0.
  - RETRY_CNT=0, LOSS_CNT=0, lock synchroniser flops 0.
- DCM_LOCKED passes through a 2-flop synchroniser to give lock_s (2-cycle latency). All decisions use lock_s only.
- One shared counter cnt (CNT_W bits). It is cleared on every state transition and increments otherwise.
- S_RST:
  - DCM_RST=1.
  - When cnt==RST_CYCLES-1: go to S_WAIT and drive DCM_RST=0 on that edge.
  - Result: DCM_RST is high exactly RST_CYCLES rising edges after RST falls.
  - lock_s is ignored in this state.
- S_WAIT:
  - If lock_s=1: go to S_STABLE.
  - Else if cnt==LOCK_TIMEOUT-1: go to S_RST, DCM_RST=1, RETRY_CNT+1 (saturating).
- S_STABLE:
  - If lock_s=0: go to S_WAIT with a fresh timeout count; no counter increments.
  - Else if cnt==LOCK_STABLE-1: go to S_RELEASE.
- S_RELEASE:
  - On the entering edge CH_RST[0] goes 0.
  - CH_RST[i] goes 0 on the edge where cnt==i*STAGGER-1, so channel i is released i*STAGGER cycles after channel 0.
  - When the last channel is released: go to S_RUN and set READY=1 on that same edge.
  - For N_CH=1: go to S_RUN and set READY=1 on the entering edge.
- S_RUN: hold all outputs.
- Released channels stay released until a lock loss or RST.
- Lock loss (lock_s=0) in S_RELEASE or S_RUN, on the same edge:
  - CH_RST all ones, READY=0, DCM_RST=1.
  - Go to S_RST; LOSS_CNT+1 (saturating).
- Priority when events coincide on one edge:
  - Lock loss beats a release step or the entry to S_RUN.
  - In S_WAIT, lock_s=1 beats timeout.
  - In S_STABLE, lock_s=0 beats completion.
- Counters saturate at 255 and never wrap.
- No combinational path from any input to any output.

Test Plan:
- Params RST_CYCLES=8, LOCK_TIMEOUT=32, LOCK_STABLE=4, N_CH=3, STAGGER=2; RST released, DCM_LOCKED tied 1 -> DCM_RST high for 8 edges.
  - STATE sequence 0->1->2->3->4.
  - CH_RST 111->110->100->000 at 2-cycle spacing.
  - READY=1 on the edge CH_RST becomes 000; RETRY_CNT=0.
- DCM_LOCKED held 0 for 200 cycles -> DCM_RST re-pulses every 40 cycles (8 high + 32 wait); RETRY_CNT counts 1,2,3,...; CH_RST stays 111.
- Lock glitch: DCM_LOCKED low for 1 cycle in the middle of S_STABLE -> return to S_WAIT, then to S_STABLE with the count restarted. Release happens 4 cycles after the last relock, not earlier.
- Lock loss in S_RUN -> on the edge lock_s falls: CH_RST=111, READY=0, DCM_RST=1, LOSS_CNT=1. The full sequence repeats and LOSS_CNT stays at 1.
- Lock loss while CH_RST=110 in S_RELEASE -> CH_RST returns to 111, S_RST, no further channel releases.
  - Separately: force 300 timeouts -> RETRY_CNT stays at 255.
- RST asserted asynchronously mid-S_RELEASE (between clock edges) -> outputs return to reset values immediately without a clock edge.
  - RETRY_CNT and LOSS_CNT cleared; the sequence restarts after RST falls.
